// File: rtl/mmio_xbar_pkg.sv
`timescale 1ns/1ps
// Shared encodings, address map and region helper for the MMIO crossbar.
// No logic of its own.
package mmio_xbar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_D  = 3'd2,
        ST_WR_A  = 3'd3,
        ST_WR_B  = 3'd4,
        ST_ERR_R = 3'd5,
        ST_ERR_B = 3'd6
    } state_e;

    typedef logic [1:0] sel_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int   NUM_SLAVES = 3;
    localparam sel_t SEL_SRAM   = 2'd0;
    localparam sel_t SEL_UART   = 2'd1;
    localparam sel_t SEL_CLINT  = 2'd2;
    localparam sel_t SEL_NONE   = 2'd3;

    localparam logic [31:0] S0_BASE = 32'h8000_0000;
    localparam logic [31:0] S0_SIZE = 32'h0800_0000;
    localparam logic [31:0] S1_BASE = 32'hA000_03F8;
    localparam logic [31:0] S1_SIZE = 32'h0000_0008;
    localparam logic [31:0] S2_BASE = 32'hA000_0048;
    localparam logic [31:0] S2_SIZE = 32'h0000_0010;

    // Unsigned wrap makes addresses below base land far above size.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [31:0] off;
        off = addr - base;
        return (off < size);
    endfunction

endpackage

// File: rtl/mmio_decode.sv
`timescale 1ns/1ps
// Combinational address-to-slave decode; zero latency, no handshake.
// Overlapping regions resolve to the lowest slave index.
module mmio_decode
    import mmio_xbar_pkg::*;
(
    input  logic [31:0] addr_i,
    output sel_t        sel_o
);

    // Later assignments override earlier ones, so slave 0 is checked last.
    always_comb begin
        sel_o = SEL_NONE;
        if (in_region(addr_i, S2_BASE, S2_SIZE)) sel_o = SEL_CLINT;
        if (in_region(addr_i, S1_BASE, S1_SIZE)) sel_o = SEL_UART;
        if (in_region(addr_i, S0_BASE, S0_SIZE)) sel_o = SEL_SRAM;
    end

endmodule

// File: rtl/mmio_xbar.sv
`timescale 1ns/1ps
// One-master/three-slave MMIO crossbar, one transaction in flight; 3-cycle minimum read/write.
// Handshakes are routed combinationally to the selected slave; unmapped requests get a local DECERR.
module mmio_xbar
    import mmio_xbar_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        up_arvalid,
    output logic        up_arready,
    input  logic [31:0] up_araddr,
    output logic        up_rvalid,
    input  logic        up_rready,
    output logic [31:0] up_rdata,
    output logic [1:0]  up_rresp,
    input  logic        up_awvalid,
    output logic        up_awready,
    input  logic [31:0] up_awaddr,
    input  logic        up_wvalid,
    output logic        up_wready,
    input  logic [31:0] up_wdata,
    input  logic [3:0]  up_wstrb,
    input  logic        up_wen,
    output logic        up_bvalid,
    input  logic        up_bready,
    output logic [1:0]  up_bresp,

    output logic [2:0]  s_arvalid,
    input  logic [2:0]  s_arready,
    output logic [31:0] s_araddr,
    input  logic [2:0]  s_rvalid,
    output logic [2:0]  s_rready,
    input  logic [95:0] s_rdata,
    input  logic [5:0]  s_rresp,
    output logic [2:0]  s_awvalid,
    input  logic [2:0]  s_awready,
    output logic [31:0] s_awaddr,
    output logic [2:0]  s_wvalid,
    input  logic [2:0]  s_wready,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic [2:0]  s_wen,
    input  logic [2:0]  s_bvalid,
    output logic [2:0]  s_bready,
    input  logic [5:0]  s_bresp,

    output logic        err_valid,
    output logic [31:0] err_addr
);

    state_e      state_q, state_d;
    sel_t        sel_q, sel_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        ar_done_q, ar_done_d;
    logic        err_valid_q, err_valid_d;
    logic [31:0] err_addr_q, err_addr_d;

    sel_t        ar_sel;
    sel_t        aw_sel;
    logic [2:0]  sel_oh;

    mmio_decode u_ar_decode (
        .addr_i (up_araddr),
        .sel_o  (ar_sel)
    );

    mmio_decode u_aw_decode (
        .addr_i (up_awaddr),
        .sel_o  (aw_sel)
    );

    // SEL_NONE shifts the one-hot out of range, giving an all-zero mask.
    assign sel_oh = 3'b001 << sel_q;

    assign s_araddr  = up_araddr;
    assign s_awaddr  = up_awaddr;
    assign s_wdata   = up_wdata;
    assign s_wstrb   = up_wstrb;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ar_done_d   = ar_done_q;
        err_valid_d = 1'b0;
        err_addr_d  = err_addr_q;

        up_arready  = 1'b0;
        up_rvalid   = 1'b0;
        up_rdata    = '0;
        up_rresp    = '0;
        up_awready  = 1'b0;
        up_wready   = 1'b0;
        up_bvalid   = 1'b0;
        up_bresp    = '0;
        s_arvalid   = '0;
        s_rready    = '0;
        s_awvalid   = '0;
        s_wvalid    = '0;
        s_wen       = '0;
        s_bready    = '0;

        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                ar_done_d = 1'b0;
                if (up_awvalid || up_wvalid) begin
                    sel_d = aw_sel;
                    if (aw_sel == SEL_NONE) begin
                        state_d     = ST_ERR_B;
                        err_valid_d = 1'b1;
                        err_addr_d  = up_awaddr;
                    end else begin
                        state_d = ST_WR_A;
                    end
                end else if (up_arvalid) begin
                    sel_d = ar_sel;
                    if (ar_sel == SEL_NONE) begin
                        state_d     = ST_ERR_R;
                        err_valid_d = 1'b1;
                        err_addr_d  = up_araddr;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end
            end

            ST_RD_A: begin
                s_arvalid  = sel_oh & {3{up_arvalid}};
                up_arready = |(s_arready & sel_oh);
                if (up_arvalid && up_arready) state_d = ST_RD_D;
            end

            ST_RD_D: begin
                up_rvalid = |(s_rvalid & sel_oh);
                s_rready  = sel_oh & {3{up_rready}};
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (sel_oh[k]) begin
                        up_rdata = s_rdata[32*k +: 32];
                        up_rresp = s_rresp[2*k +: 2];
                    end
                end
                if (up_rvalid && up_rready) state_d = ST_RD_A == ST_RD_A ? ST_IDLE : ST_IDLE;
            end

            // aw and w progress independently; each is forwarded until it fires once.
            ST_WR_A: begin
                s_awvalid  = sel_oh & {3{up_awvalid && !aw_done_q}};
                up_awready = !aw_done_q && |(s_awready & sel_oh);
                s_wvalid   = sel_oh & {3{up_wvalid && !w_done_q}};
                up_wready  = !w_done_q && |(s_wready & sel_oh);
                s_wen      = sel_oh & {3{up_wen}};
                if (up_awvalid && up_awready) aw_done_d = 1'b1;
                if (up_wvalid && up_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)    state_d   = ST_WR_B;
            end

            ST_WR_B: begin
                up_bvalid = |(s_bvalid & sel_oh);
                s_bready  = sel_oh & {3{up_bready}};
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (sel_oh[k]) up_bresp = s_bresp[2*k +: 2];
                end
                if (up_bvalid && up_bready) state_d = ST_IDLE;
            end

            ST_ERR_R: begin
                if (!ar_done_q) begin
                    up_arready = 1'b1;
                    if (up_arvalid) ar_done_d = 1'b1;
                end else begin
                    up_rvalid = 1'b1;
                    up_rresp  = RESP_DECERR;
                    if (up_rready) state_d = ST_IDLE;
                end
            end

            ST_ERR_B: begin
                if (!(aw_done_q && w_done_q)) begin
                    up_awready = !aw_done_q;
                    up_wready  = !w_done_q;
                    if (up_awvalid && !aw_done_q) aw_done_d = 1'b1;
                    if (up_wvalid && !w_done_q)   w_done_d  = 1'b1;
                end else begin
                    up_bvalid = 1'b1;
                    up_bresp  = RESP_DECERR;
                    if (up_bready) state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_NONE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ar_done_q   <= ar_done_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule
